// File: rtl/mimasuo_pkg.sv
// mimasuo_pkg: session-controller state type, default parameters and counter-width helpers.
package mimasuo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        OPEN,
        LOCKOUT
    } state_t;

    localparam int DEF_CODE_LEN       = 5;
    localparam int DEF_MAX_FAIL       = 3;
    localparam int DEF_CHECK_WAIT     = 2;
    localparam int DEF_OPEN_CYCLES    = 500;
    localparam int DEF_LOCKOUT_CYCLES = 5000;
    localparam int DEF_TIMEOUT        = 1000;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mimasuo_edge.sv
// mimasuo_edge: rising-edge detector for the two digit buttons; a simultaneous rise on both is rejected.
module mimasuo_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn0,
    input  logic i_btn1,
    output logic o_rise0,
    output logic o_rise1
);

    logic [1:0] r_level;
    logic       w_up0;
    logic       w_up1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_level <= '0;
        else        r_level <= {i_btn1, i_btn0};
    end

    assign w_up0   = i_btn0 & ~r_level[0];
    assign w_up1   = i_btn1 & ~r_level[1];
    assign o_rise0 = w_up0 & ~w_up1;
    assign o_rise1 = w_up1 & ~w_up0;

endmodule

// File: rtl/mimasuo_ctrl.sv
// mimasuo_ctrl: session controller for the mimasuo_logic lock core (digit pulses, verdict, open/lockout).
// Define MIMASUO_CTRL_TIMEOUT_EN to abandon an attempt after TIMEOUT idle cycles in ENTRY.
module mimasuo_ctrl
    import mimasuo_pkg::*;
#(
    parameter int CODE_LEN       = DEF_CODE_LEN,
    parameter int MAX_FAIL       = DEF_MAX_FAIL,
    parameter int CHECK_WAIT     = DEF_CHECK_WAIT,
    parameter int OPEN_CYCLES    = DEF_OPEN_CYCLES,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int TIMEOUT        = DEF_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          button0,
    input  logic                          button1,
    input  logic                          unlock_in,
    output logic                          core_button0,
    output logic                          core_button1,
    output logic                          core_clr,
    output logic                          door_open,
    output logic                          alarm,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int DW = cnt_width(CODE_LEN);
    localparam int TW = cnt_width(max2(max2(CHECK_WAIT, OPEN_CYCLES), max2(LOCKOUT_CYCLES, TIMEOUT)));

    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_digits, w_digits_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic [FW-1:0] r_fail, w_fail_nxt;
    logic          r_btn0, r_btn1, r_clr, w_clr_nxt;
    logic          w_rise0, w_rise1, w_press, w_accept;

    mimasuo_edge u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn0  (button0),
        .i_btn1  (button1),
        .o_rise0 (w_rise0),
        .o_rise1 (w_rise1)
    );

    assign w_press  = w_rise0 | w_rise1;
    assign w_accept = (r_state == IDLE) || (r_state == ENTRY);

    always_comb begin
        w_state_nxt  = r_state;
        w_digits_nxt = r_digits;
        w_timer_nxt  = r_timer;
        w_fail_nxt   = r_fail;
        w_clr_nxt    = 1'b0;
        unique case (r_state)
            IDLE, ENTRY: begin
                if (w_press) begin
                    if (r_digits == DW'(CODE_LEN - 1)) begin
                        w_state_nxt  = CHECK;
                        w_digits_nxt = '0;
                        w_timer_nxt  = TW'(CHECK_WAIT);
                    end else begin
                        w_state_nxt  = ENTRY;
                        w_digits_nxt = r_digits + DW'(1);
`ifdef MIMASUO_CTRL_TIMEOUT_EN
                        w_timer_nxt  = TW'(TIMEOUT - 1);
`endif
                    end
                end
`ifdef MIMASUO_CTRL_TIMEOUT_EN
                else if (r_state == ENTRY) begin
                    if (r_timer == '0) begin
                        w_state_nxt  = IDLE;
                        w_digits_nxt = '0;
                        w_clr_nxt    = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer - TW'(1);
                    end
                end
`endif
            end
            CHECK: begin
                // First CHECK cycle coincides with the last digit pulse; the core cannot answer yet.
                if (r_timer == TW'(CHECK_WAIT)) begin
                    w_timer_nxt = r_timer - TW'(1);
                end else if (unlock_in) begin
                    w_state_nxt = OPEN;
                    w_timer_nxt = TW'(OPEN_CYCLES - 1);
                end else if (r_timer == '0) begin
                    w_clr_nxt  = 1'b1;
                    w_fail_nxt = (r_fail < FW'(MAX_FAIL)) ? r_fail + FW'(1) : r_fail;
                    if (w_fail_nxt == FW'(MAX_FAIL)) begin
                        w_state_nxt = LOCKOUT;
                        w_timer_nxt = TW'(LOCKOUT_CYCLES - 1);
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            OPEN, LOCKOUT: begin
                if (r_timer == '0) begin
                    w_state_nxt = IDLE;
                    w_fail_nxt  = '0;
                    w_clr_nxt   = 1'b1;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_digits <= '0;
            r_timer  <= '0;
            r_fail   <= '0;
            r_clr    <= 1'b0;
            r_btn0   <= 1'b0;
            r_btn1   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_digits <= w_digits_nxt;
            r_timer  <= w_timer_nxt;
            r_fail   <= w_fail_nxt;
            r_clr    <= w_clr_nxt;
            r_btn0   <= w_rise0 & w_accept;
            r_btn1   <= w_rise1 & w_accept;
        end
    end

    assign core_button0 = r_btn0;
    assign core_button1 = r_btn1;
    assign core_clr     = r_clr;
    assign door_open    = (r_state == OPEN);
    assign alarm        = (r_state == LOCKOUT);
    assign fail_cnt     = r_fail;

endmodule

// File: tb/tb_mimasuo_ctrl.sv
// tb_mimasuo_ctrl: directed scenarios plus random buttons/unlock, checked every cycle against a
// deadline-based session model; honours MIMASUO_CTRL_TIMEOUT_EN.
module tb_mimasuo_ctrl;

    localparam int CODE_LEN = 5;
    localparam int MAX_FAIL = 3;
    localparam int CW       = 2;
    localparam int OPEN_C   = 8;
    localparam int LOCK_C   = 32;
    localparam int TMO      = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       button0 = 1'b0;
    logic       button1 = 1'b0;
    logic       unlock_in = 1'b0;
    logic       core_button0, core_button1, core_clr, door_open, alarm;
    logic [1:0] fail_cnt;

    int n_checks = 0;
    int n_err = 0;
    int n_door = 0, n_alarm = 0, n_clr = 0, n_btn = 0;

    always #5 clk = ~clk;

    mimasuo_ctrl #(
        .CODE_LEN       (CODE_LEN),
        .MAX_FAIL       (MAX_FAIL),
        .CHECK_WAIT     (CW),
        .OPEN_CYCLES    (OPEN_C),
        .LOCKOUT_CYCLES (LOCK_C),
        .TIMEOUT        (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .button0      (button0),
        .button1      (button1),
        .unlock_in    (unlock_in),
        .core_button0 (core_button0),
        .core_button1 (core_button1),
        .core_clr     (core_clr),
        .door_open    (door_open),
        .alarm        (alarm),
        .fail_cnt     (fail_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Session model: modes and absolute edge deadlines (edge k drives cycle k).
    int m_cyc, m_digits, m_last_act, m_chk_from, m_win_end, m_fail, m_mode;
    bit m_pb0, m_pb1, m_r0, m_r1, m_p0, m_p1;
    bit e_b0, e_b1, e_clr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_digits = 0; m_last_act = 0; m_chk_from = 0; m_win_end = 0;
            m_fail = 0; m_mode = 0; m_pb0 = 0; m_pb1 = 0;
            e_b0 = 0; e_b1 = 0; e_clr = 0;
        end else begin
            m_cyc++;
            m_r0 = button0 && !m_pb0;
            m_r1 = button1 && !m_pb1;
            m_p0 = m_r0 && !m_r1;
            m_p1 = m_r1 && !m_r0;
            m_pb0 = button0;
            m_pb1 = button1;
            e_b0 = 0; e_b1 = 0; e_clr = 0;
            case (m_mode)
                0: begin
                    if (m_p0 || m_p1) begin
                        e_b0 = m_p0;
                        e_b1 = m_p1;
                        m_digits++;
                        m_last_act = m_cyc;
                        if (m_digits == CODE_LEN) begin
                            m_mode = 1;
                            m_chk_from = m_cyc;
                            m_digits = 0;
                        end
                    end
`ifdef MIMASUO_CTRL_TIMEOUT_EN
                    else if (m_digits > 0 && m_cyc - m_last_act == TMO) begin
                        e_clr = 1;
                        m_digits = 0;
                    end
`endif
                end
                1: begin
                    if (unlock_in && m_cyc >= m_chk_from + 2) begin
                        m_mode = 2;
                        m_win_end = m_cyc + OPEN_C;
                    end else if (m_cyc == m_chk_from + 1 + CW) begin
                        e_clr = 1;
                        if (m_fail < MAX_FAIL) m_fail++;
                        if (m_fail == MAX_FAIL) begin
                            m_mode = 3;
                            m_win_end = m_cyc + LOCK_C;
                        end else begin
                            m_mode = 0;
                        end
                    end
                end
                default: begin
                    if (m_cyc == m_win_end) begin
                        e_clr = 1;
                        m_fail = 0;
                        m_mode = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("core_button0", int'(core_button0), int'(e_b0));
        chk("core_button1", int'(core_button1), int'(e_b1));
        chk("core_clr", int'(core_clr), int'(e_clr));
        chk("door_open", int'(door_open), (m_mode == 2) ? 1 : 0);
        chk("alarm", int'(alarm), (m_mode == 3) ? 1 : 0);
        chk("fail_cnt", int'(fail_cnt), m_fail);
        chk("clr_with_pulse", int'(core_clr & (core_button0 | core_button1)), 0);
        if (door_open) n_door++;
        if (alarm) n_alarm++;
        if (core_clr) n_clr++;
        if (core_button0 || core_button1) n_btn++;
    end

    task automatic step(input bit b0, input bit b1, input bit u);
        button0 = b0;
        button1 = b1;
        unlock_in = u;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0);
    endtask

    task automatic press(input int d);
        step(d == 0, d == 1, 0);
        step(0, 0, 0);
    endtask

    task automatic enter(input logic [4:0] code);
        for (int unsigned i = 0; i < 5; i++) press(int'(code[4 - i]));
    endtask

    task automatic open_attempt();
        enter(5'b01001);
        step(0, 0, 1);
        step(0, 0, 0);
    endtask

    task automatic fail_attempt();
        enter(5'b11111);
        idle(3);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_btn0"}, int'(core_button0), 0);
        chk({tag, "_btn1"}, int'(core_button1), 0);
        chk({tag, "_clr"}, int'(core_clr), 0);
        chk({tag, "_door"}, int'(door_open), 0);
        chk({tag, "_alarm"}, int'(alarm), 0);
        chk({tag, "_fail"}, int'(fail_cnt), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(2);
        chk_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Correct code, core answers one cycle after the fifth pulse.
        n_door = 0; n_clr = 0;
        open_attempt();
        idle(12);
        chk("open_len", n_door, 8);
        chk("open_clr", n_clr, 1);
        chk("open_fail", int'(fail_cnt), 0);

        // Three wrong attempts -> lockout with presses discarded.
        fail_attempt();
        chk("fail1", int'(fail_cnt), 1);
        fail_attempt();
        chk("fail2", int'(fail_cnt), 2);
        n_alarm = 0; n_clr = 0;
        fail_attempt();
        chk("fail3", int'(fail_cnt), 3);
        n_btn = 0;
        repeat (5) press(int'($urandom_range(0, 1)));
        idle(30);
        chk("lock_len", n_alarm, 32);
        chk("lock_no_pulse", n_btn, 0);
        chk("lock_clr", n_clr, 2);
        chk("lock_fail", int'(fail_cnt), 0);

        // Simultaneous press, then a held button.
        n_btn = 0;
        step(1, 1, 0);
        step(0, 0, 0);
        repeat (10) step(1, 0, 0);
        step(0, 0, 0);
        chk("held_pulses", n_btn, 1);
        n_door = 0;
        press(1); press(0); press(0); press(1);
        step(0, 0, 1);
        idle(12);
        chk("held_count_open", n_door, 8);

        // Entry inactivity.
        fail_attempt();
        n_clr = 0; n_door = 0;
        press(0); press(1);
`ifdef MIMASUO_CTRL_TIMEOUT_EN
        idle(20);
        chk("tmo_clr", n_clr, 1);
        chk("tmo_fail", int'(fail_cnt), 1);
        open_attempt();
`else
        idle(100);
        chk("no_tmo_clr", n_clr, 0);
        chk("no_tmo_fail", int'(fail_cnt), 1);
        press(0); press(0); press(1);
        step(0, 0, 1);
        step(0, 0, 0);
`endif
        idle(12);
        chk("entry_open", n_door, 8);

        // Reset during OPEN.
        open_attempt();
        idle(3);
        n_clr = 0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_open");
        idle(2);
        rst_n = 1'b1;
        idle(5);
        chk("rst_open_noclr", n_clr, 0);
        n_door = 0;
        open_attempt();
        idle(12);
        chk("rst_open_reopen", n_door, 8);

        // Reset during LOCKOUT.
        repeat (3) fail_attempt();
        idle(5);
        n_clr = 0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_lock");
        idle(2);
        rst_n = 1'b1;
        idle(5);
        chk("rst_lock_noclr", n_clr, 0);
        n_door = 0;
        open_attempt();
        idle(12);
        chk("rst_lock_reopen", n_door, 8);

        // Presses during CHECK and OPEN are discarded.
        n_door = 0;
        enter(5'b01001);
        n_btn = 0;
        step(1, 0, 1);
        step(0, 0, 0);
        press(1); press(0); press(1);
        idle(6);
        chk("busy_no_pulse", n_btn, 0);
        open_attempt();
        idle(12);
        chk("busy_reopen", n_door, 16);

        // Random traffic.
        for (int unsigned i = 0; i < 3000; i++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
